// File: rtl/ctta_result_fifo.sv
// Result FIFO for CTTA words with saturating running sum, sticky overflow flag and
// optional running maximum (enabled by defining CTTA_FIFO_MAX_EN).
module ctta_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SUM_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [4:0]               q,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [4:0]               out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [SUM_W-1:0]         sum,
  output logic                     ovf,
  output logic [4:0]               max_q
);

  localparam int unsigned DW  = 5;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned SXW = SUM_W + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [SXW-1:0]   sum_ext_c;
  logic             full_c, empty_c, push_c, pop_c;

  // Handshake decode; a full FIFO refuses input even when a pop happens this cycle.
  always_comb begin
    full_c  = (count_q == CW'(DEPTH));
    empty_c = (count_q == '0);
    push_c  = in_valid && !full_c;
    pop_c   = out_ready && !empty_c;
  end

  // Storage write, pointer and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Statistics; clear overrides any same-cycle push or overflow event.
  always_comb begin
    sum_ext_c = {1'b0, sum_q} + SXW'(q);
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    if (push_c) begin
      sum_d = sum_ext_c[SUM_W] ? {SUM_W{1'b1}} : sum_ext_c[SUM_W-1:0];
    end
    if (in_valid && full_c) begin
      ovf_d = 1'b1;
    end
    if (clr) begin
      sum_d = '0;
      ovf_d = 1'b0;
    end
  end

  // Storage array carries no reset; empty reads are masked at the output.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef CTTA_FIFO_MAX_EN
  logic [DW-1:0] max_val_q, max_val_d;

  always_comb begin
    max_val_d = max_val_q;
    if (push_c && (q > max_val_q)) begin
      max_val_d = q;
    end
    if (clr) begin
      max_val_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_val_q <= '0;
    end else begin
      max_val_q <= max_val_d;
    end
  end

  assign max_q = max_val_q;
`else
  assign max_q = '0;
`endif

  assign in_ready  = !full_c;
  assign out_valid = !empty_c;
  assign out_data  = empty_c ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;

endmodule
